// File: rtl/demux_1x2_x64_buf.sv
// Registered 1-to-2 stream demultiplexer with a private FIFO per output.
// Each accepted word goes to the FIFO chosen by in_sel, so a stalled consumer
// only blocks traffic aimed at its own channel.
// Optional macro DEMUX_STATS_EN adds per-channel delivered-word counters on
// xfer_cnt; without it xfer_cnt is tied to zero.
module demux_1x2_x64_buf #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sel,
  input  logic [WIDTH-1:0]           in_data,
  output logic [1:0]                 out_valid,
  input  logic [1:0]                 out_ready,
  output logic [1:0][WIDTH-1:0]      out_data,
  output logic [1:0][CNT_W-1:0]      xfer_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;

  // Ready depends only on registered fullness of the selected channel, never on out_ready.
  assign in_ready  = ~full[in_sel];
  assign out_valid = ~empty;

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [PW-1:0]                 wptr;
    logic [PW-1:0]                 rptr;
    logic [DEPTH-1:0][WIDTH-1:0]   mem;
    logic [AW-1:0]                 last_idx;

    assign full[k]  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty[k] = (wptr == rptr);
    assign push[k]  = in_valid & in_ready & (in_sel == 1'(k));
    assign pop[k]   = ~empty[k] & out_ready[k];

    // Slot behind the read pointer holds the most recently popped word, so an
    // empty channel keeps presenting its last head rather than an older entry.
    assign last_idx    = rptr[AW-1:0] - AW'(1);
    assign out_data[k] = empty[k] ? mem[last_idx] : mem[rptr[AW-1:0]];

    // FIFO storage and pointers; reset discards every buffered word.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wptr <= '0;
        rptr <= '0;
        mem  <= '0;
      end else begin
        if (push[k]) begin
          mem[wptr[AW-1:0]] <= in_data;
          wptr              <= wptr + 1'b1;
        end
        if (pop[k]) begin
          rptr <= rptr + 1'b1;
        end
      end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt;

    // Count words delivered to this channel's consumer, wrapping naturally.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (pop[k]) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign xfer_cnt[k] = cnt;
`else
    assign xfer_cnt[k] = '0;
`endif
  end

endmodule

// File: tb/tb_demux_1x2_x64_buf.sv
// Directed, table-driven bench for demux_1x2_x64_buf (DEPTH=2).
module tb_demux_1x2_x64_buf;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [63:0]      in_data;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][63:0] out_data;
  logic [1:0][15:0] xfer_cnt;

  int unsigned checks;
  int unsigned errors;

  demux_1x2_x64_buf #(.WIDTH(64), .DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        sel;
    logic [63:0] data;
    logic [1:0]  ordy;
    logic        exp_rdy;   // in_ready before the edge
    logic [1:0]  exp_ov;    // out_valid after the edge
    logic [63:0] exp_d0;    // out_data[0] after the edge (if valid)
    logic [63:0] exp_d1;    // out_data[1] after the edge (if valid)
    int unsigned c0;        // delivered count ch0 after the edge
    int unsigned c1;        // delivered count ch1 after the edge
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int unsigned n);
`ifdef DEMUX_STATS_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic apply(input vec_t v, input int idx);
    in_valid  = v.iv;
    in_sel    = v.sel;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    check($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(v.exp_ov));
    if (v.exp_ov[0]) check($sformatf("v%0d out_data0", idx), out_data[0], v.exp_d0);
    if (v.exp_ov[1]) check($sformatf("v%0d out_data1", idx), out_data[1], v.exp_d1);
    check($sformatf("v%0d xfer_cnt0", idx), 64'(xfer_cnt[0]), 64'(cnt_exp(v.c0)));
    check($sformatf("v%0d xfer_cnt1", idx), 64'(xfer_cnt[1]), 64'(cnt_exp(v.c1)));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 1'b0;
    in_data   = '0;
    out_ready = 2'b11;

    //           iv  sel data                    ordy   rdy  ov     d0                      d1                      c0 c1
    vecs[0] = '{1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5, 2'b11, 1'b1, 2'b01, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 64'h0F0F0F0F0F0F0F0F, 2'b11, 1'b1, 2'b01, 64'h0F0F0F0F0F0F0F0F, 64'h0, 1, 0};
    vecs[2] = '{1'b0, 1'b0, 64'h0,                2'b11, 1'b1, 2'b00, 64'h0,                64'h0, 2, 0};
    vecs[3] = '{1'b1, 1'b0, 64'h1111,             2'b10, 1'b1, 2'b01, 64'h1111,             64'h0, 2, 0};
    vecs[4] = '{1'b1, 1'b0, 64'h2222,             2'b10, 1'b1, 2'b01, 64'h1111,             64'h0, 2, 0};
    vecs[5] = '{1'b1, 1'b0, 64'h3333,             2'b10, 1'b0, 2'b01, 64'h1111,             64'h0, 2, 0};
    vecs[6] = '{1'b1, 1'b1, 64'h4444,             2'b10, 1'b1, 2'b11, 64'h1111,             64'h4444, 2, 0};
    vecs[7] = '{1'b1, 1'b0, 64'h3333,             2'b11, 1'b0, 2'b01, 64'h2222,             64'h0, 3, 1};
    vecs[8] = '{1'b1, 1'b0, 64'h3333,             2'b11, 1'b1, 2'b01, 64'h3333,             64'h0, 4, 1};
    vecs[9] = '{1'b0, 1'b0, 64'h0,                2'b11, 1'b1, 2'b00, 64'h0,                64'h0, 5, 1};

    // Reset state while reset_n is low
    #12;
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst out_data0", out_data[0], 64'h0);
    check("rst out_data1", out_data[1], 64'h0);
    check("rst xfer_cnt0", 64'(xfer_cnt[0]), 64'h0);
    check("rst xfer_cnt1", 64'(xfer_cnt[1]), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle in_ready", 64'(in_ready), 64'h1);
    check("idle out_valid", 64'(out_valid), 64'h0);

    for (int i = 0; i < 10; i++) apply(vecs[i], i);

    // Fresh counters, then alternate channels every cycle with no stalls
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_sel    = 1'(i % 2);
      in_data   = 64'h100 + 64'(i);
      out_ready = 2'b11;
      #1;
      check($sformatf("alt%0d in_ready", i), 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      check($sformatf("alt%0d out_valid", i), 64'(out_valid), (i % 2 == 1) ? 64'h2 : 64'h1);
      check($sformatf("alt%0d out_data", i), out_data[i % 2], 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("alt drain out_valid", 64'(out_valid), 64'h0);
    check("alt xfer_cnt0", 64'(xfer_cnt[0]), 64'(cnt_exp(8)));
    check("alt xfer_cnt1", 64'(xfer_cnt[1]), 64'(cnt_exp(8)));

    // Fill both channels partly, then reset asynchronously mid-cycle
    out_ready = 2'b00;
    in_valid  = 1'b1;
    in_sel = 1'b0; in_data = 64'hAAAA; @(posedge clk); #1;
    in_sel = 1'b1; in_data = 64'hBBBB; @(posedge clk); #1;
    in_sel = 1'b0; in_data = 64'hCCCC; @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-rst out_valid", 64'(out_valid), 64'h3);
    check("pre-rst out_data0", out_data[0], 64'hAAAA);
    check("pre-rst in_ready0", 64'(in_ready), 64'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'h0);
    check("async rst out_data0", out_data[0], 64'h0);
    check("async rst out_data1", out_data[1], 64'h0);
    #1;
    reset_n   = 1'b1;
    out_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-rst%0d out_valid", i), 64'(out_valid), 64'h0);
      check($sformatf("post-rst%0d in_ready", i), 64'(in_ready), 64'h1);
    end
    check("post-rst xfer_cnt0", 64'(xfer_cnt[0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
